// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: one synchronous SRAM port shared by fetch and data.
// Optional ARB_RR_EN macro: round-robin tie-break instead of data-first.
// Ports: clk, reset (async, active-high); inst_* fetch requester;
//   data_* load/store requester; mem_* shared SRAM port; busy = not IDLE.
module sram_port_arbiter #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_ack,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_ack,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic       owner_q;
  logic       grant;
  logic       pick_data;

`ifdef ARB_RR_EN
  // 1 = data was granted last; reset to data so inst wins the first tie
  logic last_data_q;

  assign pick_data = data_req & (~inst_req | ~last_data_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_data_q <= 1'b1;
    end else if (grant) begin
      last_data_q <= pick_data;
    end
  end
`else
  assign pick_data = data_req;
`endif

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inst_req | data_req) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mem_en/mem_wen are loaded on the grant edge so they are high exactly
  // during ISSUE; address and write data stay put until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= 1'b0;
      cnt_q      <= 4'd0;
      mem_en     <= 1'b0;
      mem_wen    <= 4'd0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_wen  <= 4'd0;
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      if (grant) begin
        owner_q <= pick_data;
        mem_en  <= 1'b1;
        if (pick_data) begin
          mem_addr  <= data_addr;
          mem_wen   <= data_wen;
          mem_wdata <= data_wdata;
        end else begin
          mem_addr  <= inst_addr;
          mem_wen   <= 4'd0;
          mem_wdata <= 32'd0;
        end
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_INIT;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_q == WAIT && cnt_q == 4'd0) begin
        if (owner_q) begin
          data_rdata <= mem_rdata;
          data_ack   <= 1'b1;
        end else begin
          inst_rdata <= mem_rdata;
          inst_ack   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: randomized + directed scoreboard bench.
// Transaction-level model predicts issue/ack cycles and data per grant.
module tb_sram_port_arbiter;

  localparam int LAT = 3;
  localparam int AW  = 32;
  localparam int NC  = 8192;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [31:0]   inst_rdata;
  logic          inst_ack;
  logic          data_req;
  logic [3:0]    data_wen;
  logic [AW-1:0] data_addr;
  logic [31:0]   data_wdata;
  logic [31:0]   data_rdata;
  logic          data_ack;
  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .LATENCY(LAT),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_rdata(inst_rdata),
    .inst_ack  (inst_ack),
    .data_req  (data_req),
    .data_wen  (data_wen),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .data_ack  (data_ack),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } iss_t;

  typedef struct {
    int          cyc;
    bit          is_data;
    bit          chk_rd;
    logic [31:0] rdata;
  } ack_t;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  iss_t        iss_q[$];
  ack_t        ack_q[$];
  txn_t        inst_todo[$];
  txn_t        data_todo[$];
  logic [31:0] rd_tab[NC];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int free_at = 0;
  int busy_lo = 1;
  int busy_hi = 0;
  int i_done = 0;
  int d_done = 0;
  bit model_on = 0;
  bit mon_on = 0;
  bit rand_on = 0;
  bit last_data = 1;
  bit i_pend = 0;
  bit i_gnt = 0;
  bit d_pend = 0;
  bit d_gnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // memory returns a fresh random word every cycle
  assign mem_rdata = rd_tab[cyc % NC];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents an output
  iss_t e;
  ack_t a;
  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_en) begin
        if (iss_q.size() == 0) begin
          chk("issue_unexpected", mem_en, 0);
        end else begin
          e = iss_q.pop_front();
          chk("issue_cycle", cyc, e.cyc);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wen", mem_wen, e.wen);
          chk("mem_wdata", mem_wdata, e.wdata);
        end
      end else begin
        chk("mem_wen_idle", mem_wen, 0);
        if (iss_q.size() != 0 && iss_q[0].cyc <= cyc) begin
          void'(iss_q.pop_front());
          chk("issue_missing", mem_en, 1);
        end
      end
      if (inst_ack || data_ack) begin
        chk("ack_onehot", inst_ack & data_ack, 0);
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", {inst_ack, data_ack}, 0);
        end else begin
          a = ack_q.pop_front();
          chk("ack_cycle", cyc, a.cyc);
          chk("ack_owner", data_ack, a.is_data);
          if (a.chk_rd) begin
            chk("rdata", a.is_data ? data_rdata : inst_rdata, a.rdata);
          end
        end
      end else if (ack_q.size() != 0 && ack_q[0].cyc <= cyc) begin
        void'(ack_q.pop_front());
        chk("ack_missing", inst_ack | data_ack, 1);
      end
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  // requesters: hold req until ack; may reissue in the cycle after ack
  task automatic drive();
    txn_t t;
    if (i_gnt && cyc > i_done) begin
      i_gnt    = 0;
      inst_req = 0;
    end
    if (i_gnt) begin
      inst_addr = $urandom();
      if (rand_on && $urandom_range(7) == 0) inst_req = 0;
    end
    if (!i_pend && !i_gnt && inst_todo.size() != 0) begin
      t         = inst_todo.pop_front();
      inst_req  = 1;
      inst_addr = t.addr;
      i_pend    = 1;
    end
    if (d_gnt && cyc > d_done) begin
      d_gnt    = 0;
      data_req = 0;
    end
    if (d_gnt) begin
      data_addr  = $urandom();
      data_wdata = $urandom();
      data_wen   = 4'($urandom());
      if (rand_on && $urandom_range(7) == 0) data_req = 0;
    end
    if (!d_pend && !d_gnt && data_todo.size() != 0) begin
      t          = data_todo.pop_front();
      data_req   = 1;
      data_wen   = t.wen;
      data_addr  = t.addr;
      data_wdata = t.wdata;
      d_pend     = 1;
    end
  endtask

  // reference: one transaction per LAT+3 cycles, granted when free
  task automatic model();
    bit pd;
    int t0;
    if (model_on && cyc >= free_at && (inst_req || data_req)) begin
      t0 = cyc;
`ifdef ARB_RR_EN
      if (inst_req && data_req) pd = !last_data;
      else pd = data_req;
      last_data = pd;
`else
      pd = data_req;
`endif
      if (pd) begin
        iss_q.push_back('{t0 + 1, data_addr, data_wen, data_wdata});
        ack_q.push_back('{t0 + LAT + 2, 1'b1, (data_wen == 4'd0),
                          rd_tab[(t0 + 1 + LAT) % NC]});
        d_pend = 0;
        d_gnt  = 1;
        d_done = t0 + LAT + 2;
      end else begin
        iss_q.push_back('{t0 + 1, inst_addr, 4'd0, 32'd0});
        ack_q.push_back('{t0 + LAT + 2, 1'b0, 1'b1,
                          rd_tab[(t0 + 1 + LAT) % NC]});
        i_pend = 0;
        i_gnt  = 1;
        i_done = t0 + LAT + 2;
      end
      busy_lo = t0 + 1;
      busy_hi = t0 + LAT + 2;
      free_at = t0 + LAT + 3;
    end
  endtask

  task automatic tick();
    logic [3:0] w;
    @(posedge clk);
    #1;
    if (rand_on) begin
      if (inst_todo.size() == 0 && $urandom_range(2) == 0)
        inst_todo.push_back('{4'd0, $urandom(), 32'd0});
      if (data_todo.size() == 0 && $urandom_range(2) == 0) begin
        w = $urandom_range(1) != 0 ? 4'($urandom()) : 4'd0;
        data_todo.push_back('{w, $urandom(), $urandom()});
      end
    end
    drive();
    model();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_inst_rdata"}, inst_rdata, 0);
    chk({tag, "_data_rdata"}, data_rdata, 0);
    chk({tag, "_inst_ack"}, inst_ack, 0);
    chk({tag, "_data_ack"}, data_ack, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset     = 0;
    free_at   = cyc;
    busy_lo   = 1;
    busy_hi   = 0;
    last_data = 1;
    model_on  = 1;
    mon_on    = 1;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) rd_tab[i] = $urandom();
    reset      = 1;
    inst_req   = 0;
    inst_addr  = '0;
    data_req   = 0;
    data_wen   = '0;
    data_addr  = '0;
    data_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    release_reset();

    // fetch read only
    inst_todo.push_back('{4'd0, 32'hBFC0_0000, 32'd0});
    run(12);
    // simultaneous fetch and load
    data_todo.push_back('{4'd0, 32'h8000_1000, 32'd0});
    inst_todo.push_back('{4'd0, 32'hBFC0_0004, 32'd0});
    run(20);
    // partial store
    data_todo.push_back('{4'b0011, 32'h0000_0004, 32'h1234_5678});
    run(10);
    // both requesters continuously busy
    for (int i = 0; i < 4; i++) begin
      data_todo.push_back('{4'd0, 32'h8000_2000 + 32'(i * 4), 32'd0});
      inst_todo.push_back('{4'd0, 32'hBFC0_1000 + 32'(i * 4), 32'd0});
    end
    run(60);

    // random traffic with drops and late input changes
    rand_on = 1;
    run(1500);
    rand_on = 0;
    for (int i = 0; i < 500; i++) begin
      if (iss_q.size() == 0 && ack_q.size() == 0 && inst_todo.size() == 0 &&
          data_todo.size() == 0 && !i_gnt && !d_gnt && !i_pend && !d_pend)
        break;
      tick();
    end
    chk("drain", iss_q.size() + ack_q.size() + inst_todo.size() +
        data_todo.size(), 0);

    // reset while waiting on memory
    inst_todo.push_back('{4'd0, 32'hBFC0_0040, 32'd0});
    for (int i = 0; i < 20 && !i_gnt; i++) tick();
    chk("rst_test_granted", i_gnt, 1);
    run(2);
    chk("rst_test_busy", busy, 1);
    #2;
    mon_on   = 0;
    model_on = 0;
    reset    = 1;
    #1;
    check_zero("async_rst");
    iss_q.delete();
    ack_q.delete();
    inst_todo.delete();
    data_todo.delete();
    i_pend   = 0;
    i_gnt    = 0;
    d_pend   = 0;
    d_gnt    = 0;
    inst_req = 0;
    data_req = 0;
    @(posedge clk);
    release_reset();
    run(12);
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous SRAM port between the instruction-fetch requester and the data-access requester.
- Used when the CPU core is moved onto a single unified memory port in place of separate inst/data SRAM ports.
- Sits between the PC/fetch logic plus the memory stage, and the external memory.
- Runs a 4-state FSM per transaction: arbitrate, issue, wait a fixed read latency, return data with a one-cycle acknowledge.

Parameters:
- LATENCY, 1, cycles from the issue cycle (mem_en high) until mem_rdata is valid; legal range 1..15.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch request; held high until inst_ack.
- inst_addr  in  ADDR_W  fetch address.
- inst_rdata  out  32  fetch data; valid while inst_ack is high.
- inst_ack  out  1  one-cycle completion pulse for fetch.
- data_req  in  1  data request; held high until data_ack.
- data_wen  in  4  byte write enables; 4'b0000 means read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  32  store data.
- data_rdata  out  32  load data; valid while data_ack is high.
- data_ack  out  1  one-cycle completion pulse for data.
- mem_en  out  1  shared port enable.
- mem_wen  out  4  shared port byte write enables.
- mem_addr  out  ADDR_W  shared port address.
- mem_wdata  out  32  shared port write data.
- mem_rdata  in  32  shared port read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: asynchronous; state=IDLE.
  - All outputs 0: mem_en, mem_wen, mem_addr, mem_wdata, inst_rdata, data_rdata, inst_ack, data_ack, busy.
  - Internal latency counter and owner flag cleared.
  - Reset mid-transaction abandons it; no ack is produced after release.
- IDLE: samples inst_req and data_req.
  - If neither is high, stay in IDLE.
  - Otherwise grant: data beats inst under fixed priority.
  - On grant, latch owner, address, wen and wdata (wen/wdata forced to 0 for inst); go to ISSUE.
- ISSUE (1 cycle): mem_en=1; mem_addr, mem_wen and mem_wdata driven from the latched values; go to WAIT.
- WAIT (LATENCY cycles):
  - Counter loads LATENCY-1 on entry and decrements each cycle.
  - mem_en=0 and mem_wen=0 throughout.
  - On the cycle the count reaches 0, register mem_rdata into the owner's rdata; go to RESP.
- RESP (1 cycle): the owner's ack=1, the other ack=0; go to IDLE.
- Registered outputs: mem_addr and mem_wdata hold their last values outside ISSUE.
  - inst_rdata/data_rdata hold until that requester's next capture.
- Latency: request high in IDLE cycle t0 -> mem_en in t0+1 -> ack in t0+LATENCY+2.
  - Minimum spacing between grants is LATENCY+3 cycles.
- Writes use the same timing as reads. data_rdata captures mem_rdata regardless; its value is don't-care for writes.
- Requester rules:
  - Inputs are sampled only in IDLE; later changes to addr/wen/wdata are ignored.
  - req dropped before ack: the transaction still completes and ack still pulses.
  - req still high in the cycle after ack: treated as a new request.
- The same requester re-requesting back-to-back is allowed.
- At most one ack is high in any cycle, and at most one transaction is in flight.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last_grant flag is updated at every grant; reset value = data, so inst wins the first tie.
  - On simultaneous requests, grant the requester not granted last.
  - A single request is granted regardless of the flag.
- Undefined: fixed data-over-inst priority. Inst can be starved while data_req stays high.

Test Plan:
1. Inst-only read: inst_req=1, inst_addr=0xBFC00000, mem_rdata=0x3C1D0000, LATENCY=1.
   -> mem_en high only in t0+1 with mem_addr=0xBFC00000 and mem_wen=0.
   -> inst_ack only in t0+3 with inst_rdata=0x3C1D0000; data_ack stays 0.
2. Tie, no macro: inst_req=data_req=1 in t0, data read of 0x80001000.
   -> data issued t0+1, data_ack t0+3.
   -> inst issued t0+5, inst_ack t0+7.
3. Partial write: data_wen=4'b0011, data_addr=0x00000004, data_wdata=0x12345678.
   -> in t0+1: mem_en=1, mem_wen=4'b0011, mem_wdata=0x12345678.
   -> data_ack at t0+3; mem_wen=0 in every other cycle.
4. Reset mid-transaction: reset asserted asynchronously during WAIT.
   -> all outputs 0 before the next edge.
   -> after release with no requests: no ack, busy=0, state IDLE.
5. LATENCY=3, inst read: mem_en at t0+1, mem_rdata sampled at t0+4, inst_ack at t0+5.
6. Both requests held high for 4 transactions.
   -> with ARB_RR_EN: grant order inst, data, inst, data.
   -> without ARB_RR_EN: data served every time, no inst_ack.
